// File: rtl/accel_pkg.sv
// Shared types and constants for the inference accelerator control path.
package accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_RDWAIT,
        ST_ARGMAX,
        ST_DONE
    } state_t;

    localparam int unsigned LANES   = 10;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned WADDR_W = 7;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned IDX_W   = 4;

    // Extract signed lane i from a packed result vector (lane i = bits [8i+7:8i]).
    function automatic logic signed [LANE_W-1:0] lane_of(
        input logic [LANES*LANE_W-1:0] vec,
        input logic [IDX_W-1:0]        i
    );
        return vec[i*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/layer_sequencer_argmax.sv
// Sequential argmax over the 10 signed result lanes, one lane per cycle.
// The load cycle itself scans lane 0 straight from the input vector, so a
// full scan takes exactly LANES cycles; idx/valid describe the lane being
// scanned this cycle, letting the caller register the final winner on the
// same edge that finishes the scan.
module argmax_seq
    import accel_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [LANES*LANE_W-1:0]   vec,
    output logic [IDX_W-1:0]          idx,
    output logic                      valid
);

    logic [LANES*LANE_W-1:0] vec_q;
    logic                    active;
    logic [IDX_W-1:0]        cnt_q;
    logic signed [LANE_W-1:0] best_val;
    logic [IDX_W-1:0]        best_idx;

    logic                    scanning;
    logic [IDX_W-1:0]        cur_idx;
    logic signed [LANE_W-1:0] cur_val;
    logic                    take;

    // Current lane compare; strictly greater wins so ties keep the lower index.
    always_comb begin
        scanning = load || active;
        cur_idx  = load ? '0 : cnt_q;
        cur_val  = load ? lane_of(vec, '0) : lane_of(vec_q, cnt_q);
        take     = load || (cur_val > best_val);
        idx      = take ? cur_idx : best_idx;
        valid    = scanning && (cur_idx == IDX_W'(LANES - 1));
    end

    // Scan state: captured vector, running best and lane counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q    <= '0;
            active   <= 1'b0;
            cnt_q    <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else if (scanning) begin
            if (load) begin
                vec_q <= vec;
            end
            if (take) begin
                best_val <= cur_val;
            end
            best_idx <= idx;
            cnt_q    <= cur_idx + 1'b1;
            active   <= !valid;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Control FSM for one inference layer: steps the weight/input buffers,
// strobes the PE line, writes the accumulated vector to the result buffer
// and, for layer 1, scans it back for the winning class index.
module layer_sequencer
    import accel_pkg::*;
#(
    parameter int unsigned IN_LEN0 = 100,
    parameter int unsigned IN_LEN1 = 10,
    parameter int unsigned PE_LAT  = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      layer,
    output logic                      busy,
    output logic                      done,
    output logic                      weight_we,
    output logic [WADDR_W-1:0]        weight_addr,
    output logic                      input_we,
    output logic [WADDR_W-1:0]        input_addr,
    output logic                      pe_clear,
    output logic                      pe_valid,
    output logic                      result_we,
    output logic [RADDR_W-1:0]        result_addr,
    input  logic [LANES*LANE_W-1:0]   result_data,
    output logic [IDX_W-1:0]          inference_result,
    output logic                      result_valid
);

    localparam logic [WADDR_W-1:0] LAST0      = WADDR_W'(IN_LEN0 - 1);
    localparam logic [WADDR_W-1:0] LAST1      = WADDR_W'(IN_LEN1 - 1);
    localparam logic [7:0]         DRAIN_LAST = 8'(PE_LAT);

    state_t             state;
    logic               layer_q;
    logic [WADDR_W-1:0] last_k;
    logic [7:0]         drain_cnt;
    logic               issue;
    logic               arg_load;
    logic [IDX_W-1:0]   arg_idx;
    logic               arg_valid;

    assign weight_we  = 1'b0;
    assign input_we   = 1'b0;
    assign input_addr = weight_addr;

    argmax_seq u_argmax (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (arg_load),
        .vec   (result_data),
        .idx   (arg_idx),
        .valid (arg_valid)
    );

    // Main sequencer: state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            layer_q          <= 1'b0;
            last_k           <= '0;
            drain_cnt        <= '0;
            issue            <= 1'b0;
            arg_load         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            weight_addr      <= '0;
            pe_clear         <= 1'b0;
            pe_valid         <= 1'b0;
            result_we        <= 1'b0;
            result_addr      <= '0;
            inference_result <= '0;
            result_valid     <= 1'b0;
        end else begin
            // pe_valid trails the issue flag by the buffer read latency
            pe_valid  <= issue;
            pe_clear  <= 1'b0;
            done      <= 1'b0;
            result_we <= 1'b0;
            arg_load  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        layer_q      <= layer;
                        last_k       <= layer ? LAST1 : LAST0;
                        weight_addr  <= '0;
                        issue        <= 1'b1;
                        pe_clear     <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (weight_addr == last_k) begin
                        state     <= ST_DRAIN;
                        issue     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        weight_addr <= weight_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state       <= ST_WRITE;
                        result_we   <= 1'b1;
                        result_addr <= {{(RADDR_W-1){1'b0}}, layer_q};
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (layer_q) begin
                        state <= ST_RDWAIT;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_RDWAIT: begin
                    // read data is valid in the first ARGMAX cycle
                    state    <= ST_ARGMAX;
                    arg_load <= 1'b1;
                end
                ST_ARGMAX: begin
                    if (arg_valid) begin
                        state            <= ST_DONE;
                        done             <= 1'b1;
                        inference_result <= arg_idx;
                        result_valid     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: cycle-offset model of one layer run plus
// directed checks, including a second instance with a one-row layer 0.
module tb_layer_sequencer;
    import accel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, layer;
    logic        busy, done, weight_we, input_we, pe_clear, pe_valid, result_we, result_valid;
    logic [6:0]  weight_addr, input_addr;
    logic [3:0]  result_addr, inference_result;
    logic [79:0] result_data = '0;

    logic        b_start, b_layer;
    logic        b_busy, b_done, b_weight_we, b_input_we, b_pe_clear, b_pe_valid, b_result_we, b_result_valid;
    logic [6:0]  b_weight_addr, b_input_addr;
    logic [3:0]  b_result_addr, b_inference_result;
    logic [79:0] b_result_data = '0;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    logic [79:0] mem [0:15];
    int vec_tie[10]  = '{5, -3, 7, 7, 0, 0, 0, 0, 0, 0};
    int vec_min[10]  = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    int vec_six[10]  = '{1, 1, 1, -5, 1, 1, 50, 1, 49, 1};
    int vec_dec[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};

    layer_sequencer #(.IN_LEN0(100), .IN_LEN1(10), .PE_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .busy(busy), .done(done), .weight_we(weight_we), .weight_addr(weight_addr),
        .input_we(input_we), .input_addr(input_addr), .pe_clear(pe_clear),
        .pe_valid(pe_valid), .result_we(result_we), .result_addr(result_addr),
        .result_data(result_data), .inference_result(inference_result),
        .result_valid(result_valid)
    );

    layer_sequencer #(.IN_LEN0(1), .IN_LEN1(10), .PE_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .layer(b_layer),
        .busy(b_busy), .done(b_done), .weight_we(b_weight_we), .weight_addr(b_weight_addr),
        .input_we(b_input_we), .input_addr(b_input_addr), .pe_clear(b_pe_clear),
        .pe_valid(b_pe_valid), .result_we(b_result_we), .result_addr(b_result_addr),
        .result_data(b_result_data), .inference_result(b_inference_result),
        .result_valid(b_result_valid)
    );

    // Result buffer: synchronous read, one cycle latency, read suppressed while writing.
    always @(posedge clk) begin
        if (!result_we) result_data <= mem[result_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] pack(input int v[10]);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[i*8 +: 8] = v[i][7:0];
        return r;
    endfunction

    function automatic int argmax_of(input logic [79:0] v);
        int best, bv, x;
        best = 0;
        bv = $signed(v[7:0]);
        for (int i = 1; i < 10; i++) begin
            x = $signed(v[i*8 +: 8]);
            if (x > bv) begin
                bv = x;
                best = i;
            end
        end
        return best;
    endfunction

    // Model: t counts cycles since the accepted start (t=1 is the first RUN cycle).
    bit         running = 1'b0;
    int         t = 0;
    bit         m_layer = 1'b0;
    int         m_len = 0;
    int         m_T = 0;
    logic [3:0] exp_ir = '0;
    bit         exp_rv = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            running = 1'b0;
            t = 0;
            exp_ir = '0;
            exp_rv = 1'b0;
        end else if (running) begin
            t++;
            if (t > m_T) begin
                running = 1'b0;
                t = 0;
            end else if (t == m_T && m_layer) begin
                exp_ir = 4'(argmax_of(mem[1]));
                exp_rv = 1'b1;
            end
        end else if (start) begin
            running = 1'b1;
            t = 1;
            m_layer = layer;
            m_len = layer ? 10 : 100;
            m_T = m_len + 5 + (layer ? 11 : 0);
            exp_rv = 1'b0;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, running);
            chk("done", done, running && t == m_T);
            chk("pe_clear", pe_clear, running && t == 1);
            chk("pe_valid", pe_valid, running && t >= 2 && t <= m_len + 1);
            chk("result_we", result_we, running && t == m_len + 4);
            chk("we_tied", {weight_we, input_we}, 0);
            chk("addr_eq", input_addr, weight_addr);
            if (running && t >= 1 && t <= m_len) chk("weight_addr", weight_addr, t - 1);
            if (running && t >= m_len + 4) chk("result_addr", result_addr, m_layer);
            chk("inference_result", inference_result, exp_ir);
            chk("result_valid", result_valid, exp_rv);
        end
    end

    task automatic run(input bit l, input int inj1, input int inj2, output int lat);
        @(negedge clk);
        layer = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 400) begin
            if (lat == inj1 || lat == inj2) begin
                start = 1'b1;
                layer = ~l;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; layer = 1'b0; b_start = 1'b0; b_layer = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = pack(vec_dec);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_waddr", weight_addr, 0);
        chk("rst_raddr", result_addr, 0);
        chk("rst_we", result_we, 0);
        chk("rst_pe", {pe_clear, pe_valid}, 0);
        chk("rst_ir", inference_result, 0);
        chk("rst_rv", result_valid, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        run(1'b0, 0, 0, lat);
        chk("lat_l0", lat, 105);
        chk("rv_l0", result_valid, 0);

        mem[1] = pack(vec_tie);
        run(1'b1, 0, 0, lat);
        chk("lat_l1", lat, 26);
        chk("ir_tie", inference_result, 2);
        chk("rv_l1", result_valid, 1);

        mem[1] = pack(vec_min);
        run(1'b1, 0, 0, lat);
        chk("lat_min", lat, 26);
        chk("ir_min", inference_result, 0);

        mem[1] = pack(vec_six);
        run(1'b1, 4, 20, lat);
        chk("lat_ignore_l1", lat, 26);
        chk("ir_six", inference_result, 6);
        run(1'b0, 50, 0, lat);
        chk("lat_ignore_l0", lat, 105);
        chk("ir_hold", inference_result, 6);

        // Reset while draining
        @(negedge clk);
        layer = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (101) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_we", result_we, 0);
        chk("mid_waddr", weight_addr, 0);
        chk("mid_pe", {pe_clear, pe_valid}, 0);
        chk("mid_ir", inference_result, 0);
        chk("mid_rv", result_valid, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        mem[1] = pack(vec_tie);
        run(1'b1, 0, 0, lat);
        chk("lat_after_rst", lat, 26);
        chk("ir_after_rst", inference_result, 2);

        // One-row layer 0 on the second instance
        @(negedge clk);
        b_layer = 1'b0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("len1_clear", b_pe_clear, 1);
        chk("len1_addr", b_weight_addr, 0);
        chk("len1_busy", b_busy, 1);
        @(negedge clk);
        chk("len1_valid", b_pe_valid, 1);
        chk("len1_clear_off", b_pe_clear, 0);
        @(negedge clk);
        chk("len1_valid_off", b_pe_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("len1_we", b_result_we, 1);
        chk("len1_raddr", b_result_addr, 0);
        @(negedge clk);
        chk("len1_done", b_done, 1);
        @(negedge clk);
        chk("len1_idle", {b_busy, b_done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control FSM for one inference layer on the parallel PE line. After `start` it steps the weight and input buffers through one layer's rows and drives the PE accumulate and clear strobes. It then writes the 10-lane accumulated vector into the result buffer. For layer 1 it also reads that vector back and scans it sequentially to produce the 4-bit class index (`inference_result`). It sits inside `accelerator`, between the three buffers and the PE line.

## Interface
Parameters:
- `IN_LEN0`, default 100: rows processed in layer 0 (1..128).
- `IN_LEN1`, default 10: rows processed in layer 1 (1..128).
- `PE_LAT`, default 2: PE line pipeline depth in cycles, from `pe_valid` to the accumulator being updated.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: start request, sampled only in IDLE.
- `layer` in 1: layer select, latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a layer completes.
- `weight_we` out 1: weight buffer write enable, tied 0.
- `weight_addr` out 7: weight row address.
- `input_we` out 1: input buffer write enable, tied 0.
- `input_addr` out 7: input word address (always equal to `weight_addr`).
- `pe_clear` out 1: zero the PE accumulators.
- `pe_valid` out 1: the buffer data this cycle is a valid accumulate operand.
- `result_we` out 1: result buffer write enable.
- `result_addr` out 4: result buffer address.
- `result_data` in 80: result buffer read data; 10 signed 8-bit lanes, lane i = bits [8i+7:8i].
- `inference_result` out 4: index of the winning class.
- `result_valid` out 1: high from the `done` of a layer-1 run until the next accepted `start`.

## Operation
- All buffers are synchronous read with 1-cycle latency.
- IDLE:
  - `start=1` → latch `layer` and set `len = layer ? IN_LEN1 : IN_LEN0`.
  - Clear `k`, clear `result_valid`, go to RUN.
  - `start=0` → stay in IDLE.
- RUN:
  - `weight_addr = input_addr = k`.
  - `pe_clear=1` in the first RUN cycle only.
  - `pe_valid` is the RUN-issue flag delayed by 1 cycle, so it aligns with the returned data.
  - `k` increments each cycle; after issuing `k = len-1`, go to DRAIN.
- DRAIN: hold for 1+`PE_LAT` cycles, then go to WRITE.
- WRITE:
  - `result_we=1` for one cycle, `result_addr = {3'b0, layer}`.
  - Layer 0 → DONE; layer 1 → RDWAIT.
- RDWAIT: `result_we=0`, address held; one cycle for read latency, then go to ARGMAX.
- ARGMAX:
  - Scan lanes 0..9, one per cycle, 10 cycles in total.
  - Signed compare; a lane replaces the current best only if strictly greater, so a tie goes to the lowest index.
  - Go to DONE.
- DONE:
  - `done=1` for one cycle.
  - Layer 1: `inference_result` updated and `result_valid=1`.
  - Return to IDLE.
- `start` outside IDLE is ignored, and is not queued.
- `inference_result` holds its value until the next layer-1 completion.

## Timing
- Reset value 0 on every output: `busy`, `done`, all addresses, all enables, `pe_clear`, `pe_valid`, `inference_result`, `result_valid`.
- Reset mid-operation: return to IDLE on the next edge, with no write and no `done`.
- All outputs are registered.
- Cycles from `start` accepted to `done`:
  - Layer 0: `len` + (1+`PE_LAT`) + 1 + 1.
  - Layer 1: the layer-0 count plus 1 (RDWAIT) + 10 (ARGMAX).
- `len=1`: RUN lasts exactly one cycle, and `pe_clear` and the issue flag are asserted in that same cycle.
- The address counter never wraps, because `len ≤ 128` is a parameter constraint.

## Structure
- Shared package `accel_pkg`, holding:
  - the state enum (IDLE, RUN, DRAIN, WRITE, RDWAIT, ARGMAX, DONE);
  - `LANES=10` and `LANE_W=8`;
  - `WADDR_W=7` and `RADDR_W=4`.
- One sub-module, `argmax_seq`: load pulse plus an 80-bit vector in; 10-cycle sequential scan; `idx[3:0]` and `valid` out.

## Test plan
- Layer 0, defaults:
  - stimulus: `start` pulse;
  - addresses 0..99 on consecutive cycles;
  - `pe_clear` once;
  - `pe_valid` high for 100 cycles, lagging the address by 1;
  - `result_we` at `result_addr=0`;
  - `done` 105 cycles after `start`;
  - `result_valid=0`.
- Layer 1:
  - stimulus: lanes `{5,-3,7,7,0,...}`;
  - `inference_result=2` (tie goes to the lower index);
  - `result_valid=1`;
  - `done` at 26 cycles.
- Layer 1, all lanes equal to -128 → `inference_result=0`.
- `start` during RUN, and again during ARGMAX → ignored: no restart, timing unchanged.
- `rst_n=0` in DRAIN:
  - next cycle all outputs are 0 and no `result_we`;
  - a fresh `start` then runs normally.
- `IN_LEN0=1`:
  - single RUN cycle with `pe_clear` and issue together;
  - `done` 6 cycles after `start`.
